mem_refill_responder: RTL

- Memory-side responder for the instruction/data cache refill interface.
- Accepts a line refill request (mem_req, mem_addr) and returns 4 consecutive 32-bit words, each with a one-cycle mem_ack pulse.
- Backed by an internal word array that a loader port preloads.
- Serves as the memory model for cache bring-up and as the template for a later bus bridge.

---
 rtl/mem_refill_responder.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_refill_responder.sv
// ============================================================================
//  Module   : mem_refill_responder
//  Purpose  : Memory-side responder for the cache refill interface. Accepts a
//             line refill request and returns four consecutive words from an
//             internal preloadable array, one mem_ack pulse per word.
//  Ports    : clk, reset_n (sync, active low)
//             mem_req / mem_addr      - refill request and line address
//             mem_ack / mem_data      - registered beat strobe and beat data
//             mem_err                 - out-of-range beat flag (optional)
//             ld_en / ld_addr / ld_data - array preload write port
//             busy                    - high whenever not IDLE
//  Options  : MEM_RESP_RANGE_CHECK_EN - adds mem_err; out-of-range lines are
//             answered with 32'hDEADBEEF instead of wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

module mem_refill_responder #(
    parameter int MEM_WORDS     = 1024,
    parameter int FIRST_LATENCY = 4,
    parameter int BEAT_GAP      = 0,
    parameter int LINE_WORDS    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mem_req,
    input  logic [`XLEN-1:0] mem_addr,
    output logic             mem_ack,
    output logic [`XLEN-1:0] mem_data,
`ifdef MEM_RESP_RANGE_CHECK_EN
    output logic             mem_err,
`endif
    input  logic             ld_en,
    input  logic [`XLEN-1:0] ld_addr,
    input  logic [`XLEN-1:0] ld_data,
    output logic             busy
);

    localparam int         c_AW        = $clog2(MEM_WORDS);
    localparam logic [3:0] c_FIRST_CNT = 4'(FIRST_LATENCY - 1);
    localparam logic [3:0] c_GAP_CNT   = 4'((BEAT_GAP > 0) ? (BEAT_GAP - 1) : 0);
    localparam logic [1:0] c_LAST_BEAT = 2'(LINE_WORDS - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_BEAT = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_TURN = 3'd4;

    logic [`XLEN-1:0] r_mem [0:MEM_WORDS-1];

    logic [2:0]       r_state;
    logic [3:0]       r_cnt;
    logic [1:0]       r_beat;
    logic [c_AW-3:0]  r_line;
    logic             r_ack;
    logic [`XLEN-1:0] r_data;
    logic             r_busy;

    logic [2:0]       w_state_nxt;
    logic [3:0]       w_cnt_nxt;
    logic [1:0]       w_beat_nxt;
    logic             w_accept;
    logic             w_beat_load;
    logic [c_AW-1:0]  w_rd_idx;
    logic [`XLEN-1:0] w_rd_data;
    logic             w_unused;

    // Next-state logic. A dropped request in any data-phase state aborts
    // straight to TURN; TURN never looks at mem_req.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_beat_nxt  = r_beat;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_req) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = c_FIRST_CNT;
                    w_beat_nxt  = 2'd0;
                    w_accept    = 1'b1;
                end
            end
            S_WAIT: begin
                if (!mem_req) begin
                    w_state_nxt = S_TURN;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt = S_BEAT;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_BEAT: begin
                if (!mem_req || (r_beat == c_LAST_BEAT)) begin
                    w_state_nxt = S_TURN;
                end else begin
                    w_beat_nxt = r_beat + 2'd1;
                    if (BEAT_GAP > 0) begin
                        w_state_nxt = S_GAP;
                        w_cnt_nxt   = c_GAP_CNT;
                    end else begin
                        w_state_nxt = S_BEAT;
                    end
                end
            end
            S_GAP: begin
                if (!mem_req) begin
                    w_state_nxt = S_TURN;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt = S_BEAT;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_TURN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered, so a beat is produced on the edge that enters
    // BEAT; the word index uses the beat number that becomes current there.
    assign w_beat_load = (w_state_nxt == S_BEAT);
    assign w_rd_idx    = {r_line, w_beat_nxt};

`ifdef MEM_RESP_RANGE_CHECK_EN
    logic r_oor;
    logic r_err;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_oor <= |mem_addr[`XLEN-1:c_AW+2];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_beat_load & r_oor;
        end
    end

    assign w_rd_data = r_oor ? `XLEN'(32'hDEADBEEF) : r_mem[w_rd_idx];
    assign mem_err   = r_err;
`else
    assign w_rd_data = r_mem[w_rd_idx];
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_beat  <= 2'd0;
            r_ack   <= 1'b0;
            r_data  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_beat  <= w_beat_nxt;
            r_ack   <= w_beat_load;
            r_busy  <= (w_state_nxt != S_IDLE);
            if (w_beat_load) begin
                r_data <= w_rd_data;
            end
        end
    end

    // Line index only; the beat counter supplies the low word bits, which
    // aligns the line and drops address bits above the array depth.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_line <= mem_addr[c_AW+1:4];
        end
    end

    // Array is never cleared by reset. Reads above use the pre-edge contents,
    // so a same-edge write to the word being read returns the old value.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            r_mem[ld_addr[c_AW+1:2]] <= ld_data;
        end
    end

    assign mem_ack  = r_ack;
    assign mem_data = r_data;
    assign busy     = r_busy;

    assign w_unused = ^{mem_addr, ld_addr};

endmodule

`default_nettype wire
